// File: rtl/instr_mem_prefetch.sv
// Instruction memory with a sequential prefetcher feeding a show-ahead buffer.
// Fetch issues one synchronous read per cycle while the buffer, counting the
// read still in flight, has room. Out-of-range or misaligned fetch addresses
// produce a single fault entry and halt fetch until the next redirect.
//
// Consumer handshake: the head entry transfers on every rising edge where
// instr_valid and instr_ready are both 1. instr_valid never depends on
// instr_ready. While instr_valid=1 and instr_ready=0, the head is held stable.
// A redirect on an edge overrides any transfer on that same edge.
module instr_mem_prefetch #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int RESET_PC   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fault,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              dbg_state
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_fetch_pc;

    // Read stage: the one read in flight between issue and buffer push.
    logic              r_rd_valid;
    logic              r_rd_fault;
    logic [ADDR_W-1:0] r_rd_pc;
    logic [DATA_W-1:0] r_rd_data;

    // Prefetch buffer storage and bookkeeping.
    logic [DATA_W-1:0] r_fifo_data  [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc    [FIFO_DEPTH];
    logic              r_fifo_fault [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [ADDR_W-1:0] w_fetch_idx;
    logic [ADDR_W-1:0] w_wr_idx;
    logic              w_bad;
    logic [CNT_W-1:0]  w_occ;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_wr_ok;

    assign w_fetch_idx = r_fetch_pc >> 2;
    assign w_wr_idx    = wr_addr >> 2;
    assign w_bad       = (w_fetch_idx >= ADDR_W'(DEPTH)) || (r_fetch_pc[1:0] != 2'b00);
    // Occupancy includes the in-flight read so a full buffer is never overrun.
    assign w_occ       = r_count + CNT_W'(r_rd_valid);
    assign w_issue     = !redirect && (r_state == ST_FETCH) && (w_occ < CNT_W'(FIFO_DEPTH));
    assign w_push      = r_rd_valid && !redirect;
    assign w_pop       = instr_valid && instr_ready && !redirect;
    assign w_wr_ok     = wr_en && (w_wr_idx < ADDR_W'(DEPTH));

    assign instr_valid = (r_count != '0);
    assign instr       = instr_valid ? r_fifo_data[r_rd_ptr]  : '0;
    assign instr_pc    = instr_valid ? r_fifo_pc[r_rd_ptr]    : '0;
    assign fault       = instr_valid ? r_fifo_fault[r_rd_ptr] : 1'b0;
    assign dbg_state   = r_state;

    // Memory array: program-load write and read-first registered fetch read.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_wr_idx[MEM_AW-1:0]] <= wr_data;
        end
        if (w_issue) begin
            r_rd_data <= w_bad ? '0 : r_mem[w_fetch_idx[MEM_AW-1:0]];
        end
    end

    // Fetch FSM: issues reads, tracks the in-flight read, halts on a bad address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FETCH;
            r_fetch_pc <= ADDR_W'(RESET_PC);
            r_rd_valid <= 1'b0;
            r_rd_fault <= 1'b0;
            r_rd_pc    <= '0;
        end else if (redirect) begin
            r_state    <= ST_FETCH;
            r_fetch_pc <= pc_in;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_issue;
            if (w_issue) begin
                r_rd_pc    <= r_fetch_pc;
                r_rd_fault <= w_bad;
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
                if (w_bad) begin
                    r_state <= ST_HALT;
                end
            end
        end
    end

    // Buffer pointers and count; a redirect empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Buffer storage: capture the completed read at the tail.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr]  <= r_rd_data;
            r_fifo_pc[r_wr_ptr]    <= r_rd_pc;
            r_fifo_fault[r_wr_ptr] <= r_rd_fault;
        end
    end

endmodule
